// File: rtl/seg_scroll_ctrl_if.sv
// Display-controller interface: load handshake from the requester and the
// registered per-position digit codes / blank mask toward the segment decoder.
// Optional blink_en signal present only when SEG_BLINK_EN is defined.
interface seg_scroll_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_scroll;
    logic        stop;
    logic [31:0] dig_code;
    logic [7:0]  dig_blank;
    logic        busy;
`ifdef SEG_BLINK_EN
    logic        blink_en;
`endif

    modport master (
        output in_valid, in_data, in_scroll, stop,
`ifdef SEG_BLINK_EN
        output blink_en,
`endif
        input  in_ready, dig_code, dig_blank, busy
    );

    modport slave (
        input  in_valid, in_data, in_scroll, stop,
`ifdef SEG_BLINK_EN
        input  blink_en,
`endif
        output in_ready, dig_code, dig_blank, busy
    );
endinterface

// File: rtl/seg_scroll_ctrl.sv
// Eight-digit seven-segment sequencer. Latches an 8-nibble word and either shows
// it statically or scrolls it in from the right, one position per prescaler tick.
// Optional feature macro SEG_BLINK_EN: blink the static display using the prescaler.
//
// state  | meaning
// IDLE   | after reset, display blanked, waiting for first word
// STATIC | word in buffer shown in full (optionally blinking)
// SCROLL | word sliding in from the right, step k = 0..15
module seg_scroll_ctrl #(
    parameter int TICK_DIV = 5000000
) (
    input  logic              clk,
    input  logic              rst,
    seg_scroll_ctrl_if.slave  disp
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STATIC = 2'd1,
        ST_SCROLL = 2'd2
    } state_t;

    state_t        state, nxt_state;
    logic [31:0]   data_buf, nxt_buf;
    logic [3:0]    step_k, nxt_k;
    logic [PW-1:0] pre_cnt, nxt_pre;
    logic          tick;
    logic [31:0]   view_code;
    logic [7:0]    view_blank;
`ifdef SEG_BLINK_EN
    logic          phase, nxt_phase;
`endif

    // Scroll window: position p shows buffer digit p+8-k when that digit exists.
    function automatic logic [39:0] scroll_view(input logic [31:0] word, input logic [3:0] k);
        logic [31:0] code;
        logic [7:0]  blank;
        int          d;
        code  = '0;
        blank = '1;
        for (int p = 0; p < 8; p++) begin
            d = p + 8 - int'(k);
            if (d >= 0 && d <= 7) begin
                code[p*4 +: 4] = word[d*4 +: 4];
                blank[p]       = 1'b0;
            end
        end
        return {blank, code};
    endfunction

    assign tick = (pre_cnt == PRE_MAX);

    // Next-state logic: handshake, scroll stepping, stop, optional blink phase.
    always_comb begin
        nxt_state = state;
        nxt_buf   = data_buf;
        nxt_k     = step_k;
        nxt_pre   = pre_cnt;
`ifdef SEG_BLINK_EN
        nxt_phase = phase;
`endif
        unique case (state)
            ST_IDLE, ST_STATIC: begin
                if (disp.in_valid) begin
                    nxt_buf   = disp.in_data;
                    nxt_k     = '0;
                    nxt_pre   = '0;
                    nxt_state = disp.in_scroll ? ST_SCROLL : ST_STATIC;
`ifdef SEG_BLINK_EN
                    nxt_phase = 1'b0;
`endif
                end
`ifdef SEG_BLINK_EN
                else if (state == ST_STATIC) begin
                    if (!disp.blink_en) begin
                        nxt_pre   = '0;
                        nxt_phase = 1'b0;
                    end else if (tick) begin
                        nxt_pre   = '0;
                        nxt_phase = ~phase;
                    end else begin
                        nxt_pre   = pre_cnt + 1'b1;
                    end
                end
`endif
            end
            ST_SCROLL: begin
                // stop has priority over a tick landing in the same cycle
                if (disp.stop) begin
                    nxt_state = ST_STATIC;
                    nxt_k     = '0;
                    nxt_pre   = '0;
`ifdef SEG_BLINK_EN
                    nxt_phase = 1'b0;
`endif
                end else if (tick) begin
                    nxt_pre = '0;
                    if (step_k == 4'd15) begin
                        nxt_state = ST_STATIC;
                        nxt_k     = '0;
`ifdef SEG_BLINK_EN
                        nxt_phase = 1'b0;
`endif
                    end else begin
                        nxt_k = step_k + 4'd1;
                    end
                end else begin
                    nxt_pre = pre_cnt + 1'b1;
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // Display image for the upcoming state, so outputs track the state with no extra lag.
    always_comb begin
        view_code  = '0;
        view_blank = 8'hFF;
        unique case (nxt_state)
            ST_STATIC: begin
                view_code  = nxt_buf;
`ifdef SEG_BLINK_EN
                view_blank = nxt_phase ? 8'hFF : 8'h00;
`else
                view_blank = 8'h00;
`endif
            end
            ST_SCROLL: {view_blank, view_code} = scroll_view(nxt_buf, nxt_k);
            default: begin
                view_code  = '0;
                view_blank = 8'hFF;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            data_buf       <= '0;
            step_k         <= '0;
            pre_cnt        <= '0;
            disp.dig_code  <= '0;
            disp.dig_blank <= 8'hFF;
            disp.in_ready  <= 1'b1;
            disp.busy      <= 1'b0;
`ifdef SEG_BLINK_EN
            phase          <= 1'b0;
`endif
        end else begin
            state          <= nxt_state;
            data_buf       <= nxt_buf;
            step_k         <= nxt_k;
            pre_cnt        <= nxt_pre;
            disp.dig_code  <= view_code;
            disp.dig_blank <= view_blank;
            disp.in_ready  <= (nxt_state != ST_SCROLL);
            disp.busy      <= (nxt_state == ST_SCROLL);
`ifdef SEG_BLINK_EN
            phase          <= nxt_phase;
`endif
        end
    end
endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Directed bench for seg_scroll_ctrl with TICK_DIV=4 (one scroll step every 4 clocks).
module tb_seg_scroll_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    seg_scroll_ctrl_if disp();

    seg_scroll_ctrl #(.TICK_DIV(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .disp (disp.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_code"},  disp.dig_code, 32'h0);
        check({tag, "_blank"}, {24'h0, disp.dig_blank}, 32'hFF);
        check({tag, "_ready"}, {31'h0, disp.in_ready}, 32'h1);
        check({tag, "_busy"},  {31'h0, disp.busy}, 32'h0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        disp.in_valid  = 1'b1;
        disp.in_data   = 32'hFFFF_FFFF;
        disp.in_scroll = 1'b1;
        disp.stop      = 1'b1;
`ifdef SEG_BLINK_EN
        disp.blink_en  = 1'b0;
`endif
        #2 rst = 1'b1;
        #1 check_reset("rst0");
        steps(2);
        check_reset("rst0_held");
        disp.in_valid = 1'b0;
        disp.stop     = 1'b0;
        rst = 1'b0;
        step();
        check_reset("idle");

        // static load
        disp.in_valid = 1'b1; disp.in_data = 32'h1234_5678; disp.in_scroll = 1'b0;
        step();
        disp.in_valid = 1'b0;
        check("st_code",  disp.dig_code, 32'h1234_5678);
        check("st_blank", {24'h0, disp.dig_blank}, 32'h0);
        check("st_busy",  {31'h0, disp.busy}, 32'h0);
        check("st_ready", {31'h0, disp.in_ready}, 32'h1);

        // static replace
        disp.in_valid = 1'b1; disp.in_data = 32'hCAFE_F00D; disp.in_scroll = 1'b0;
        step();
        disp.in_valid = 1'b0;
        check("st_repl", disp.dig_code, 32'hCAFE_F00D);

        // full scroll pass
        disp.in_valid = 1'b1; disp.in_data = 32'h8765_4321; disp.in_scroll = 1'b1;
        step();
        disp.in_valid = 1'b0;
        check("sc_busy",  {31'h0, disp.busy}, 32'h1);
        check("sc_ready", {31'h0, disp.in_ready}, 32'h0);
        check("sc_k0_blank", {24'h0, disp.dig_blank}, 32'hFF);
        check("sc_k0_code",  disp.dig_code, 32'h0);
        steps(3);
        check("sc_pre3_blank", {24'h0, disp.dig_blank}, 32'hFF);
        step();
        check("sc_k1_blank", {24'h0, disp.dig_blank}, 32'hFE);
        check("sc_k1_code",  disp.dig_code, 32'h0000_0008);
        // offered word while scrolling must be ignored
        disp.in_valid = 1'b1; disp.in_data = 32'hDEAD_BEEF; disp.in_scroll = 1'b0;
        steps(28);
        disp.in_valid = 1'b0;
        check("sc_k8_code",  disp.dig_code, 32'h8765_4321);
        check("sc_k8_blank", {24'h0, disp.dig_blank}, 32'h0);
        check("sc_k8_busy",  {31'h0, disp.busy}, 32'h1);
        steps(24);
        check("sc_k14_code",  disp.dig_code, 32'h2100_0000);
        check("sc_k14_blank", {24'h0, disp.dig_blank}, 32'h3F);
        steps(4);
        check("sc_k15_code",  disp.dig_code, 32'h1000_0000);
        check("sc_k15_blank", {24'h0, disp.dig_blank}, 32'h7F);
        steps(3);
        check("sc_k15_busy", {31'h0, disp.busy}, 32'h1);
        step();
        check("sc_end_busy",  {31'h0, disp.busy}, 32'h0);
        check("sc_end_ready", {31'h0, disp.in_ready}, 32'h1);
        check("sc_end_code",  disp.dig_code, 32'h8765_4321);
        check("sc_end_blank", {24'h0, disp.dig_blank}, 32'h0);

        // stop on the tick cycle at k=5
        disp.in_valid = 1'b1; disp.in_data = 32'h8765_4321; disp.in_scroll = 1'b1;
        step();
        disp.in_valid = 1'b0;
        steps(20);
        check("stp_k5_code",  disp.dig_code, 32'h0008_7654);
        check("stp_k5_blank", {24'h0, disp.dig_blank}, 32'hE0);
        steps(3);
        disp.stop = 1'b1;
        step();
        disp.stop = 1'b0;
        check("stp_busy",  {31'h0, disp.busy}, 32'h0);
        check("stp_code",  disp.dig_code, 32'h8765_4321);
        check("stp_blank", {24'h0, disp.dig_blank}, 32'h0);
        disp.stop = 1'b1;
        step();
        disp.stop = 1'b0;
        check("stp_static_busy", {31'h0, disp.busy}, 32'h0);
        check("stp_static_code", disp.dig_code, 32'h8765_4321);

        // reset during k=10
        disp.in_valid = 1'b1; disp.in_data = 32'h8765_4321; disp.in_scroll = 1'b1;
        step();
        disp.in_valid = 1'b0;
        steps(40);
        check("k10_code",  disp.dig_code, 32'h6543_2100);
        check("k10_blank", {24'h0, disp.dig_blank}, 32'h03);
        #2 rst = 1'b1;
        #1 check_reset("rst_mid");
        step();
        rst = 1'b0;
        step();
        check_reset("rst_after");

`ifdef SEG_BLINK_EN
        disp.blink_en = 1'b1;
        disp.in_valid = 1'b1; disp.in_data = 32'hA5A5_A5A5; disp.in_scroll = 1'b0;
        step();
        disp.in_valid = 1'b0;
        check("bl_p0_blank", {24'h0, disp.dig_blank}, 32'h0);
        steps(4);
        check("bl_p1_blank", {24'h0, disp.dig_blank}, 32'hFF);
        check("bl_p1_code",  disp.dig_code, 32'hA5A5_A5A5);
        steps(4);
        check("bl_p2_blank", {24'h0, disp.dig_blank}, 32'h0);
        steps(4);
        check("bl_p3_blank", {24'h0, disp.dig_blank}, 32'hFF);
        disp.blink_en = 1'b0;
        step();
        check("bl_off_blank", {24'h0, disp.dig_blank}, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
